// File: rtl/lcd_text_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_text_buffer_if
// Description : Bundle between the character writer / LCD bus controller and
//               the double-buffered text store.
//               Writer side: wr_en, wr_line, wr_col, wr_data, clr, commit.
//               Controller side: ready in; data, line, col, valid,
//               line_start, frame_done, commit_pending out.
//               master = upstream logic + controller, slave = lcd_text_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_text_buffer_if #(
    parameter int COLS   = 16,
    parameter int LINES  = 2,
    parameter int CHAR_W = 8
);
    localparam int CW = (COLS  > 1) ? $clog2(COLS)  : 1;
    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;

    logic              wr_en;
    logic [LW-1:0]     wr_line;
    logic [CW-1:0]     wr_col;
    logic [CHAR_W-1:0] wr_data;
    logic              clr;
    logic              commit;
    logic              ready;
    logic [CHAR_W-1:0] data;
    logic [LW-1:0]     line;
    logic [CW-1:0]     col;
    logic              valid;
    logic              line_start;
    logic              frame_done;
    logic              commit_pending;

    modport master (
        output wr_en, wr_line, wr_col, wr_data, clr, commit, ready,
        input  data, line, col, valid, line_start, frame_done, commit_pending
    );

    modport slave (
        input  wr_en, wr_line, wr_col, wr_data, clr, commit, ready,
        output data, line, col, valid, line_start, frame_done, commit_pending
    );
endinterface
`default_nettype wire

// File: rtl/lcd_text_buffer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_text_buffer
// Description : Double-buffered LINES x COLS character store with a scanner.
//               Writes and clears land in the back buffer; a commit copies
//               back to front only when the scan wraps past the last cell,
//               so the panel never shows a half-updated message.
// Ports       : clk, rst (synchronous, active-high)
//               bus (lcd_text_buffer_if.slave): write/clear/commit inputs,
//               ready handshake in, scan pointer and character out.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_text_buffer #(
    parameter int                COLS   = 16,
    parameter int                LINES  = 2,
    parameter int                CHAR_W = 8,
    parameter logic [CHAR_W-1:0] FILL   = CHAR_W'(8'hFE)
) (
    input  wire logic        clk,
    input  wire logic        rst,
    lcd_text_buffer_if.slave bus
);
    localparam int CW    = (COLS  > 1) ? $clog2(COLS)  : 1;
    localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int CELLS = LINES * COLS;
    localparam int IW    = $clog2(CELLS);

    localparam logic [CW-1:0] c_last_col  = CW'(COLS - 1);
    localparam logic [LW-1:0] c_last_line = LW'(LINES - 1);

    logic [CHAR_W-1:0] r_front [CELLS];
    logic [CHAR_W-1:0] r_back  [CELLS];
    logic [CHAR_W-1:0] w_back_next [CELLS];

    logic [LW-1:0] r_line;
    logic [CW-1:0] r_col;
    logic          r_valid;
    logic          r_frame_done;
    logic          r_commit_pending;

    logic          w_advance;
    logic          w_boundary;
    logic          w_wr_ok;
    logic [IW-1:0] w_rd_idx;
    logic [IW-1:0] w_wr_idx;

    always_comb begin
        w_advance  = r_valid && bus.ready;
        w_boundary = w_advance && (r_line == c_last_line) && (r_col == c_last_col);
        // Address fields may be wider than the populated range; such writes drop.
        w_wr_ok    = bus.wr_en && (32'(bus.wr_line) < LINES) && (32'(bus.wr_col) < COLS);
        w_rd_idx   = IW'(32'(r_line) * COLS + 32'(r_col));
        w_wr_idx   = IW'(32'(bus.wr_line) * COLS + 32'(bus.wr_col));
    end

    // Clear first, then the write, so a same-cycle write survives the clear.
    always_comb begin
        w_back_next = r_back;
        if (bus.clr) begin
            w_back_next = '{default: FILL};
        end
        if (w_wr_ok) begin
            w_back_next[w_wr_idx] = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_front          <= '{default: FILL};
            r_back           <= '{default: FILL};
            r_line           <= '0;
            r_col            <= '0;
            r_valid          <= 1'b0;
            r_frame_done     <= 1'b0;
            r_commit_pending <= 1'b0;
        end else begin
            r_valid      <= 1'b1;
            r_frame_done <= w_boundary;
            r_back       <= w_back_next;

            if (w_advance) begin
                if (r_col == c_last_col) begin
                    r_col  <= '0;
                    r_line <= (r_line == c_last_line) ? '0 : r_line + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            // The copy takes back as it stood before this cycle's write/clear.
            if (w_boundary) begin
                if (r_commit_pending || bus.commit) begin
                    r_front <= r_back;
                end
                r_commit_pending <= 1'b0;
            end else if (bus.commit) begin
                r_commit_pending <= 1'b1;
            end
        end
    end

    assign bus.data           = r_front[w_rd_idx];
    assign bus.line           = r_line;
    assign bus.col            = r_col;
    assign bus.valid          = r_valid;
    assign bus.line_start     = r_valid && (r_col == '0);
    assign bus.frame_done     = r_frame_done;
    assign bus.commit_pending = r_commit_pending;
endmodule
`default_nettype wire

// File: tb/tb_lcd_text_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_text_buffer
// Description : Self-checking bench for lcd_text_buffer: a vector table,
//               directed multi-cycle sequences, random traffic against a
//               cell-array reference model, and a ready-high sweep of the
//               4x20 and 1x8 configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_text_buffer;
    localparam int NC = 16;
    localparam int NL = 2;
    localparam int N  = NC * NL;

    logic clk;
    logic rst, rst_a, rst_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lcd_text_buffer_if #(.COLS(16), .LINES(2), .CHAR_W(8)) m_if ();
    lcd_text_buffer_if #(.COLS(20), .LINES(4), .CHAR_W(8)) a_if ();
    lcd_text_buffer_if #(.COLS(8),  .LINES(1), .CHAR_W(8)) b_if ();

    lcd_text_buffer #(.COLS(16), .LINES(2), .CHAR_W(8), .FILL(8'hFE))
        u_main (.clk(clk), .rst(rst), .bus(m_if));
    lcd_text_buffer #(.COLS(20), .LINES(4), .CHAR_W(8), .FILL(8'hFE))
        u_a (.clk(clk), .rst(rst_a), .bus(a_if));
    lcd_text_buffer #(.COLS(8), .LINES(1), .CHAR_W(8), .FILL(8'hFE))
        u_b (.clk(clk), .rst(rst_b), .bus(b_if));

    // ---------------- reference model of the 2x16 instance ----------------
    logic [7:0] mf [N];
    logic [7:0] mb [N];
    int         mpos;
    bit         mpend, mvalid, mfd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0] nb [N];
        bit adv, bnd;
        if (rst) begin
            foreach (mf[i]) begin mf[i] = 8'hFE; mb[i] = 8'hFE; end
            mpos = 0; mpend = 0; mvalid = 0; mfd = 0;
            return;
        end
        adv = mvalid && m_if.ready;
        bnd = adv && (mpos == N - 1);
        nb  = mb;
        if (m_if.clr) foreach (nb[i]) nb[i] = 8'hFE;
        if (m_if.wr_en) nb[int'(m_if.wr_line) * NC + int'(m_if.wr_col)] = m_if.wr_data;
        if (bnd) begin
            if (mpend || m_if.commit) mf = mb;
            mpend = 0;
        end else if (m_if.commit) begin
            mpend = 1;
        end
        mfd = bnd;
        if (adv) mpos = (mpos + 1) % N;
        mb = nb;
        mvalid = 1;
    endtask

    task automatic check_main();
        chk("data",           32'(m_if.data),           32'(mf[mpos]));
        chk("line",           32'(m_if.line),           32'(mpos / NC));
        chk("col",            32'(m_if.col),            32'(mpos % NC));
        chk("valid",          32'(m_if.valid),          32'(mvalid));
        chk("line_start",     32'(m_if.line_start),     32'(mvalid && (mpos % NC == 0)));
        chk("frame_done",     32'(m_if.frame_done),     32'(mfd));
        chk("commit_pending", 32'(m_if.commit_pending), 32'(mpend));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit do_check);
        @(posedge clk);
        model_step();
        #1;
        if (do_check) check_main();
    endtask

    task automatic idle();
        m_if.wr_en = 0; m_if.wr_line = '0; m_if.wr_col = '0; m_if.wr_data = '0;
        m_if.clr = 0; m_if.commit = 0; m_if.ready = 0;
    endtask

    function automatic int dpos();
        return int'(m_if.line) * NC + int'(m_if.col);
    endfunction

    task automatic adv1();
        m_if.ready = 1; step(1); m_if.ready = 0;
    endtask

    task automatic goto_pos(input int target);
        int k;
        k = 0;
        m_if.ready = 1;
        while (dpos() != target && k < 100) begin step(1); k++; end
        m_if.ready = 0;
        chk("goto_pos", 32'(dpos()), 32'(target));
    endtask

    task automatic wr(input int l, input int c, input int d);
        m_if.wr_en = 1; m_if.wr_line = 1'(l); m_if.wr_col = 4'(c); m_if.wr_data = 8'(d);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int rst, wr_en, wl, wc, wd, clr, commit, ready;
        int e_line, e_col, e_valid, e_ls, e_fd, e_pend, e_data;
    } vec_t;

    vec_t vt [9];

    initial begin
        logic [7:0] wait_s [4];
        int cnt_ls, cnt_fd;
        int a_t [$];
        int b_t [$];
        int scan_left, nonfe, last_val, last_pos, cyc;

        vt[0] = '{1,0,0,0,0,   0,0,0, 0,0,0,0,0,0,'hFE};
        vt[1] = '{1,0,0,0,0,   0,0,1, 0,0,0,0,0,0,'hFE};
        vt[2] = '{0,0,0,0,0,   0,0,1, 0,0,1,1,0,0,'hFE};
        vt[3] = '{0,0,0,0,0,   0,0,1, 0,1,1,0,0,0,'hFE};
        vt[4] = '{0,0,0,0,0,   0,1,1, 0,2,1,0,0,1,'hFE};
        vt[5] = '{0,1,0,2,'h41,0,1,0, 0,2,1,0,0,1,'hFE};
        vt[6] = '{0,0,0,0,0,   1,0,1, 0,3,1,0,0,1,'hFE};
        vt[7] = '{1,0,0,0,0,   0,0,0, 0,0,0,0,0,0,'hFE};
        vt[8] = '{0,0,0,0,0,   0,0,0, 0,0,1,1,0,0,'hFE};

        rst = 1; rst_a = 1; rst_b = 1;
        idle();
        a_if.wr_en = 0; a_if.wr_line = '0; a_if.wr_col = '0; a_if.wr_data = '0;
        a_if.clr = 0; a_if.commit = 0; a_if.ready = 0;
        b_if.wr_en = 0; b_if.wr_line = '0; b_if.wr_col = '0; b_if.wr_data = '0;
        b_if.clr = 0; b_if.commit = 0; b_if.ready = 0;

        // ---- table-driven vectors ----
        foreach (vt[i]) begin
            rst = (vt[i].rst != 0);
            m_if.wr_en = (vt[i].wr_en != 0); m_if.wr_line = 1'(vt[i].wl);
            m_if.wr_col = 4'(vt[i].wc); m_if.wr_data = 8'(vt[i].wd);
            m_if.clr = (vt[i].clr != 0); m_if.commit = (vt[i].commit != 0);
            m_if.ready = (vt[i].ready != 0);
            step(0);
            chk("vec line",       32'(m_if.line),           32'(vt[i].e_line));
            chk("vec col",        32'(m_if.col),            32'(vt[i].e_col));
            chk("vec valid",      32'(m_if.valid),          32'(vt[i].e_valid));
            chk("vec line_start", 32'(m_if.line_start),     32'(vt[i].e_ls));
            chk("vec frame_done", 32'(m_if.frame_done),     32'(vt[i].e_fd));
            chk("vec pending",    32'(m_if.commit_pending), 32'(vt[i].e_pend));
            chk("vec data",       32'(m_if.data),           32'(vt[i].e_data));
        end
        idle();

        // ---- reset check: 2 reset cycles, then 32 handshakes ----
        rst = 1; step(1); step(1);
        rst = 0; step(1);
        cnt_ls = 0; cnt_fd = 0;
        for (int i = 0; i < N; i++) begin
            if (m_if.line_start) cnt_ls++;
            m_if.ready = 1;
            step(1);
            if (m_if.frame_done) cnt_fd++;
        end
        chk("reset frame_done after 32nd", 32'(m_if.frame_done), 32'd1);
        m_if.ready = 0; step(1);
        if (m_if.frame_done) cnt_fd++;
        chk("reset line_start count", 32'(cnt_ls), 32'd2);
        chk("reset frame_done count", 32'(cnt_fd), 32'd1);

        // ---- commit at (0,3) with ready stalled, then boundary ----
        wait_s[0] = 8'h57; wait_s[1] = 8'h41; wait_s[2] = 8'h49; wait_s[3] = 8'h54;
        for (int i = 0; i < 4; i++) begin wr(0, 6 + i, wait_s[i]); step(1); end
        idle();
        goto_pos(3);
        m_if.commit = 1; step(1); m_if.commit = 0;
        chk("commit pending at (0,3)", 32'(m_if.commit_pending), 32'd1);
        chk("front still FE", 32'(m_if.data), 32'hFE);
        goto_pos(6);
        chk("old frame col6 FE", 32'(m_if.data), 32'hFE);
        goto_pos(N - 1);
        adv1();
        chk("commit frame_done", 32'(m_if.frame_done), 32'd1);
        chk("commit cleared", 32'(m_if.commit_pending), 32'd0);
        goto_pos(6);
        for (int i = 0; i < 4; i++) begin
            chk("WAIT char", 32'(m_if.data), 32'(wait_s[i]));
            adv1();
        end

        // ---- commit + write in the cycle consuming (1,15) ----
        goto_pos(N - 1);
        m_if.commit = 1; m_if.ready = 1; wr(1, 0, 8'h42);
        step(1); idle();
        chk("simul pending", 32'(m_if.commit_pending), 32'd0);
        chk("simul frame_done", 32'(m_if.frame_done), 32'd1);
        goto_pos(16);
        chk("front (1,0) old", 32'(m_if.data), 32'hFE);
        m_if.commit = 1; step(1); m_if.commit = 0;
        goto_pos(N - 1); adv1();
        goto_pos(16);
        chk("front (1,0) after 2nd commit", 32'(m_if.data), 32'h42);

        // ---- clear versus write ----
        m_if.clr = 1; wr(0, 0, 8'h31); step(1); idle();
        m_if.commit = 1; step(1); m_if.commit = 0;
        goto_pos(N - 1); adv1();
        for (int i = 0; i < N; i++) begin
            chk("clr/wr cell", 32'(m_if.data), (i == 0) ? 32'h31 : 32'hFE);
            adv1();
        end

        // ---- reset mid-operation with a pending commit ----
        goto_pos(5);
        m_if.commit = 1; step(1); m_if.commit = 0;
        chk("pending before rst", 32'(m_if.commit_pending), 32'd1);
        rst = 1; step(1);
        chk("rst valid", 32'(m_if.valid), 32'd0);
        chk("rst pos", 32'(dpos()), 32'd0);
        chk("rst pending", 32'(m_if.commit_pending), 32'd0);
        rst = 0; step(1);
        chk("post rst valid", 32'(m_if.valid), 32'd1);
        m_if.commit = 1; step(1); m_if.commit = 0;
        goto_pos(N - 1); adv1();
        for (int i = 0; i < N; i++) begin
            chk("post rst cell", 32'(m_if.data), 32'hFE);
            adv1();
        end

        // ---- random traffic against the model ----
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            m_if.wr_en   = ($urandom_range(0, 2) == 0);
            m_if.wr_line = 1'($urandom_range(0, 1));
            m_if.wr_col  = 4'($urandom_range(0, 15));
            m_if.wr_data = 8'($urandom);
            m_if.clr     = ($urandom_range(0, 19) == 0);
            m_if.commit  = ($urandom_range(0, 9) == 0);
            m_if.ready   = ($urandom_range(0, 2) != 0);
            step(1);
        end
        rst = 0; idle();

        // ---- parameter sweep, ready held high ----
        rst_a = 0; rst_b = 0; a_if.ready = 1; b_if.ready = 1;
        a_if.wr_en = 1; a_if.wr_line = 2'd0; a_if.wr_col = 5'd25; a_if.wr_data = 8'h55;
        a_if.commit = 1;
        tick();
        a_if.commit = 0; a_if.wr_line = 2'd3; a_if.wr_col = 5'd19; a_if.wr_data = 8'h44;
        tick();
        a_if.wr_en = 0;
        scan_left = -1; nonfe = 0; last_val = 0; last_pos = -1;
        for (cyc = 0; cyc < 300; cyc++) begin
            tick();
            if (a_if.frame_done) begin
                a_t.push_back(cyc);
                if (scan_left < 0) scan_left = 80;
            end
            if (scan_left > 0) begin
                if (a_if.data != 8'hFE) begin
                    nonfe++; last_val = int'(a_if.data);
                    last_pos = int'(a_if.line) * 20 + int'(a_if.col);
                end
                scan_left--;
            end
            if (b_if.frame_done) begin
                b_t.push_back(cyc);
                chk("1x8 wrap line_start", 32'(b_if.line_start), 32'd1);
                chk("1x8 wrap col", 32'(b_if.col), 32'd0);
            end
        end
        chk("4x20 pulses", 32'(a_t.size() >= 3), 32'd1);
        for (int i = 1; i < a_t.size(); i++)
            chk("4x20 frame period", 32'(a_t[i] - a_t[i-1]), 32'd80);
        chk("1x8 pulses", 32'(b_t.size() >= 30), 32'd1);
        for (int i = 1; i < b_t.size(); i++)
            chk("1x8 frame period", 32'(b_t[i] - b_t[i-1]), 32'd8);
        chk("4x20 non-FE cells", 32'(nonfe), 32'd1);
        chk("4x20 written value", 32'(last_val), 32'h44);
        chk("4x20 written pos", 32'(last_pos), 32'd79);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
